// File: rtl/player_ground_collider_pkg.sv
// Shared game definitions for the ground collider: coordinate widths, scan FSM
// encoding and the "no ground" sentinel.
package player_ground_collider_pkg;

  localparam int unsigned COORD_W          = 10;
  localparam int unsigned FEET_W           = COORD_W + 1;
  localparam int unsigned SNAP_TOL_DEFAULT = 2;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FEET_W-1:0]  feet_t;

  localparam coord_t NO_GROUND_Y = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  // Player geometry captured at scan start; feet is pre-summed at 11 bits.
  typedef struct packed {
    coord_t x;
    coord_t w;
    feet_t  feet;
  } player_snap_t;

  function automatic feet_t widen(input coord_t v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/player_ground_collider_ground_candidate_check.sv
// Combinational test of one platform entry against the player snapshot and the
// current best ground height.
module ground_candidate_check
  import player_ground_collider_pkg::*;
#(
  parameter int unsigned SNAP_TOL = SNAP_TOL_DEFAULT
) (
  input  player_snap_t       snap,
  input  logic               entry_valid,
  input  logic [COORD_W-1:0] entry_x0,
  input  logic [COORD_W-1:0] entry_x1,
  input  logic [COORD_W-1:0] entry_y,
  input  logic [COORD_W-1:0] best_y,
  output logic               qualifies,
  output logic               better
);

  feet_t player_right;
  feet_t surface_limit;

  always_comb begin
    player_right  = widen(snap.x) + widen(snap.w);
    surface_limit = widen(entry_y) + FEET_W'(SNAP_TOL);
    qualifies     = entry_valid
                    && (widen(snap.x) < widen(entry_x1))
                    && (player_right > widen(entry_x0))
                    && (surface_limit >= snap.feet);
    // Strict less-than keeps the earlier entry on equal heights.
    better        = qualifies && (entry_y < best_y);
  end

endmodule

// File: rtl/player_ground_collider.sv
// Scans the platform table once per scan_start and publishes the highest
// platform top beneath the player's feet, double-buffered behind scan_done.
module player_ground_collider
  import player_ground_collider_pkg::*;
#(
  parameter int unsigned NUM_PLATFORMS = 8,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned SNAP_TOL      = SNAP_TOL_DEFAULT
) (
  input  logic               clk_player_control,
  input  logic               reset,
  input  logic               scan_start,
  input  logic [COORD_W-1:0] player_pos_x,
  input  logic [COORD_W-1:0] player_pos_y,
  input  logic [COORD_W-1:0] player_w,
  input  logic [COORD_W-1:0] player_h,
  output logic [IDX_W-1:0]   platform_idx,
  input  logic               platform_valid,
  input  logic [COORD_W-1:0] platform_x0,
  input  logic [COORD_W-1:0] platform_x1,
  input  logic [COORD_W-1:0] platform_y,
  output logic [COORD_W-1:0] collider_ground_h_player,
  output logic               is_collider_ground_player,
  output logic               scan_busy,
  output logic               scan_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLATFORMS - 1);

  scan_state_t  state;
  player_snap_t snap;
  logic         rd_pending;
  logic         best_found;
  coord_t       best_y;
  logic         qualifies;
  logic         better;

  ground_candidate_check #(
    .SNAP_TOL (SNAP_TOL)
  ) u_check (
    .snap        (snap),
    .entry_valid (platform_valid),
    .entry_x0    (platform_x0),
    .entry_x1    (platform_x1),
    .entry_y     (platform_y),
    .best_y      (best_y),
    .qualifies   (qualifies),
    .better      (better)
  );

  always_ff @(posedge clk_player_control) begin
    if (reset) begin
      state                     <= ST_IDLE;
      platform_idx              <= '0;
      snap                      <= '0;
      rd_pending                <= 1'b0;
      best_found                <= 1'b0;
      best_y                    <= NO_GROUND_Y;
      collider_ground_h_player  <= '0;
      is_collider_ground_player <= 1'b0;
      scan_busy                 <= 1'b0;
      scan_done                 <= 1'b0;
    end else begin
      scan_done  <= 1'b0;
      rd_pending <= (state == ST_ISSUE);

      if (rd_pending && better) begin
        best_found <= 1'b1;
        best_y     <= platform_y;
      end

      case (state)
        ST_IDLE: begin
          if (scan_start) begin
            snap.x       <= player_pos_x;
            snap.w       <= player_w;
            snap.feet    <= widen(player_pos_y) + widen(player_h);
            best_found   <= 1'b0;
            best_y       <= NO_GROUND_Y;
            platform_idx <= '0;
            scan_busy    <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (platform_idx == LAST_IDX) begin
            state <= ST_DRAIN;
          end else begin
            platform_idx <= platform_idx + IDX_W'(1);
          end
        end
        ST_DRAIN: begin
          // Publish once the read of the last index has been compared.
          if (!rd_pending) begin
            collider_ground_h_player  <= best_found ? best_y : '0;
            is_collider_ground_player <= best_found;
            scan_done                 <= 1'b1;
            scan_busy                 <= 1'b0;
            state                     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_ground_collider.sv
// Self-checking bench for player_ground_collider: directed vector table, busy and
// reset sequences, and randomized scans against a behavioural model.
module tb_player_ground_collider;

  localparam int NP  = 8;
  localparam int IW  = 3;
  localparam int TOL = 2;

  typedef struct packed {
    logic       v;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y;
  } ent_t;

  typedef struct {
    logic [9:0]       px;
    logic [9:0]       py;
    logic [9:0]       pw;
    logic [9:0]       ph;
    ent_t [NP-1:0]    ents;
    logic [9:0]       exp_h;
    logic             exp_f;
  } vec_t;

  logic          clk_player_control = 1'b0;
  logic          reset;
  logic          scan_start;
  logic [9:0]    player_pos_x, player_pos_y, player_w, player_h;
  logic [IW-1:0] platform_idx;
  logic          platform_valid;
  logic [9:0]    platform_x0, platform_x1, platform_y;
  logic [9:0]    collider_ground_h_player;
  logic          is_collider_ground_player;
  logic          scan_busy;
  logic          scan_done;

  logic       tv  [NP];
  logic [9:0] tx0 [NP];
  logic [9:0] tx1 [NP];
  logic [9:0] ty  [NP];

  int checks = 0;
  int failures = 0;

  always #5 clk_player_control = ~clk_player_control;

  player_ground_collider #(
    .NUM_PLATFORMS (NP),
    .IDX_W         (IW),
    .SNAP_TOL      (TOL)
  ) dut (
    .clk_player_control        (clk_player_control),
    .reset                     (reset),
    .scan_start                (scan_start),
    .player_pos_x              (player_pos_x),
    .player_pos_y              (player_pos_y),
    .player_w                  (player_w),
    .player_h                  (player_h),
    .platform_idx              (platform_idx),
    .platform_valid            (platform_valid),
    .platform_x0               (platform_x0),
    .platform_x1               (platform_x1),
    .platform_y                (platform_y),
    .collider_ground_h_player  (collider_ground_h_player),
    .is_collider_ground_player (is_collider_ground_player),
    .scan_busy                 (scan_busy),
    .scan_done                 (scan_done)
  );

  // Platform RAM with one cycle of read latency.
  always @(posedge clk_player_control) begin
    platform_valid <= tv[platform_idx];
    platform_x0    <= tx0[platform_idx];
    platform_x1    <= tx1[platform_idx];
    platform_y     <= ty[platform_idx];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_table(input ent_t [NP-1:0] e);
    for (int k = 0; k < NP; k++) begin
      tv[k]  = e[k].v;
      tx0[k] = e[k].x0;
      tx1[k] = e[k].x1;
      ty[k]  = e[k].y;
    end
  endtask

  function automatic vec_t base_vec();
    vec_t r;
    r.px = 10'd100; r.py = 10'd200; r.pw = 10'd30; r.ph = 10'd30;
    // Invalid entries that would otherwise be the best match.
    for (int k = 0; k < NP; k++) r.ents[k] = '{1'b0, 10'd90, 10'd200, 10'd240};
    r.exp_h = 10'd0; r.exp_f = 1'b0;
    return r;
  endfunction

  // Reference: lowest surface y among valid, overlapping entries within reach of the feet.
  function automatic void model(input int px, input int py, input int pw, input int ph,
                                output int h, output int f);
    int best;
    best = -1;
    for (int k = 0; k < NP; k++) begin
      if (tv[k] && px < int'(tx1[k]) && px + pw > int'(tx0[k]) && int'(ty[k]) + TOL >= py + ph)
        if (best < 0 || int'(ty[k]) < best) best = int'(ty[k]);
    end
    f = (best >= 0) ? 1 : 0;
    h = (best >= 0) ? best : 0;
  endfunction

  function automatic int clip(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic run_scan(input string tag, input logic [9:0] px, input logic [9:0] py,
                          input logic [9:0] pw, input logic [9:0] ph, input bit scramble);
    int lat;
    @(negedge clk_player_control);
    player_pos_x = px; player_pos_y = py; player_w = pw; player_h = ph;
    scan_start = 1'b1;
    @(negedge clk_player_control);
    scan_start = 1'b0;
    chk({tag, "_busy_start"}, scan_busy, 1);
    if (scramble) begin
      player_pos_x = 10'($urandom); player_pos_y = 10'($urandom);
      player_w     = 10'($urandom); player_h     = 10'($urandom);
    end
    lat = 0;
    while (!scan_done && lat < 40) begin
      @(negedge clk_player_control);
      lat++;
    end
    chk({tag, "_latency"}, lat, NP + 2);
    chk({tag, "_busy_done"}, scan_busy, 0);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   eh, ef;
  int   dones, first_done;
  int   rpx, rpy, rpw, rph, ex0;

  initial begin
    reset = 1'b1; scan_start = 1'b0;
    player_pos_x = '0; player_pos_y = '0; player_w = '0; player_h = '0;
    for (int k = 0; k < NP; k++) begin tv[k] = 1'b0; tx0[k] = '0; tx1[k] = '0; ty[k] = '0; end

    v = base_vec(); v.ents[0] = '{1'b1, 10'd90, 10'd200, 10'd250}; v.exp_h = 250; v.exp_f = 1; vecs.push_back(v);
    v = base_vec(); v.ents[0] = '{1'b1, 10'd90, 10'd200, 10'd228}; v.exp_h = 228; v.exp_f = 1; vecs.push_back(v);
    v = base_vec(); v.ents[0] = '{1'b1, 10'd90, 10'd200, 10'd227}; v.exp_h = 0;   v.exp_f = 0; vecs.push_back(v);
    v = base_vec(); v.ents[3] = '{1'b1, 10'd0,  10'd100, 10'd250}; v.exp_h = 0;   v.exp_f = 0; vecs.push_back(v);
    v = base_vec(); v.ents[3] = '{1'b1, 10'd0,  10'd101, 10'd250}; v.exp_h = 250; v.exp_f = 1; vecs.push_back(v);
    v = base_vec(); v.ents[2] = '{1'b1, 10'd130, 10'd300, 10'd250}; v.exp_h = 0;  v.exp_f = 0; vecs.push_back(v);
    v = base_vec(); v.ents[2] = '{1'b1, 10'd129, 10'd300, 10'd250}; v.exp_h = 250; v.exp_f = 1; vecs.push_back(v);
    v = base_vec();
    v.ents[1] = '{1'b1, 10'd90, 10'd200, 10'd300};
    v.ents[5] = '{1'b1, 10'd90, 10'd200, 10'd250};
    v.ents[6] = '{1'b1, 10'd50, 10'd120, 10'd250};
    v.ents[7] = '{1'b1, 10'd90, 10'd200, 10'd260};
    v.exp_h = 250; v.exp_f = 1; vecs.push_back(v);
    v = base_vec(); v.ents[NP-1] = '{1'b1, 10'd90, 10'd200, 10'd231}; v.exp_h = 231; v.exp_f = 1; vecs.push_back(v);

    repeat (3) @(negedge clk_player_control);
    chk("reset_h", collider_ground_h_player, 0);
    chk("reset_flag", is_collider_ground_player, 0);
    chk("reset_busy", scan_busy, 0);
    chk("reset_done", scan_done, 0);
    chk("reset_idx", platform_idx, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      load_table(vecs[i].ents);
      run_scan($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].pw, vecs[i].ph, 1'b0);
      chk($sformatf("vec%0d_h", i), collider_ground_h_player, vecs[i].exp_h);
      chk($sformatf("vec%0d_flag", i), is_collider_ground_player, vecs[i].exp_f);
      @(negedge clk_player_control);
      chk($sformatf("vec%0d_single_done", i), scan_done, 0);
      chk($sformatf("vec%0d_hold_h", i), collider_ground_h_player, vecs[i].exp_h);
    end

    // Busy rules: mid-scan input change and a start while busy are both ignored.
    v = vecs[0];
    load_table(v.ents);
    @(negedge clk_player_control);
    player_pos_x = 100; player_pos_y = 200; player_w = 30; player_h = 30;
    scan_start = 1'b1;
    @(negedge clk_player_control);
    scan_start = 1'b0;
    tv[0] = 1'b1; ty[0] = 10'd229;   // table edit affects only later reads
    ty[0] = 10'd250;
    dones = 0; first_done = -1;
    for (int c = 1; c <= 2 * NP + 6; c++) begin
      @(negedge clk_player_control);
      if (c == 2) player_pos_y = 10'd0;
      if (c == 3) scan_start = 1'b1;
      if (c == 4) scan_start = 1'b0;
      if (scan_done) begin
        dones++;
        if (first_done < 0) begin
          first_done = c;
          chk("busy_rule_h", collider_ground_h_player, 250);
          chk("busy_rule_flag", is_collider_ground_player, 1);
        end
      end
      if (c == NP + 2) scan_start = 1'b1;
      if (c == NP + 3) begin
        chk("restart_accepted", scan_busy, 1);
        scan_start = 1'b0;
      end
    end
    chk("busy_rule_first_done", first_done, NP + 2);
    chk("busy_rule_done_count", dones, 2);

    // Snapshot check: feet at 30 from the restart; a platform at y=20 is out of reach.
    v = base_vec(); v.ents[4] = '{1'b1, 10'd90, 10'd200, 10'd20};
    load_table(v.ents);
    run_scan("low_feet", 10'd100, 10'd0, 10'd30, 10'd30, 1'b0);
    chk("low_feet_flag", is_collider_ground_player, 0);
    chk("low_feet_h", collider_ground_h_player, 0);

    // Reset mid-scan after a completed scan left results on the outputs.
    load_table(vecs[0].ents);
    run_scan("pre_reset", 10'd100, 10'd200, 10'd30, 10'd30, 1'b0);
    chk("pre_reset_h", collider_ground_h_player, 250);
    @(negedge clk_player_control);
    scan_start = 1'b1;
    @(negedge clk_player_control);
    scan_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_player_control);
      if (c == 4) reset = 1'b1;
    end
    @(negedge clk_player_control);
    reset = 1'b0;
    chk("midreset_h", collider_ground_h_player, 0);
    chk("midreset_flag", is_collider_ground_player, 0);
    chk("midreset_busy", scan_busy, 0);
    chk("midreset_done", scan_done, 0);
    chk("midreset_idx", platform_idx, 0);
    dones = 0;
    for (int c = 0; c < NP + 4; c++) begin
      @(negedge clk_player_control);
      if (scan_done) dones++;
    end
    chk("midreset_no_done", dones, 0);
    run_scan("post_reset", 10'd100, 10'd200, 10'd30, 10'd30, 1'b0);
    chk("post_reset_h", collider_ground_h_player, 250);

    // Randomized scans; player inputs are scrambled mid-scan to exercise the snapshot.
    for (int it = 0; it < 40; it++) begin
      rpx = int'($urandom_range(0, 700));
      rpy = int'($urandom_range(0, 600));
      rpw = int'($urandom_range(1, 120));
      rph = int'($urandom_range(1, 120));
      for (int k = 0; k < NP; k++) begin
        tv[k]  = ($urandom_range(0, 3) != 0);
        ex0    = clip(rpx + int'($urandom_range(0, 200)) - 120, 1023);
        tx0[k] = 10'(ex0);
        tx1[k] = 10'(clip(ex0 + int'($urandom_range(0, 150)), 1023));
        ty[k]  = 10'(clip(rpy + rph + int'($urandom_range(0, 60)) - 8, 1000));
      end
      model(rpx, rpy, rpw, rph, eh, ef);
      run_scan($sformatf("rnd%0d", it), 10'(rpx), 10'(rpy), 10'(rpw), 10'(rph), 1'b1);
      chk($sformatf("rnd%0d_h", it), collider_ground_h_player, eh);
      chk($sformatf("rnd%0d_flag", it), is_collider_ground_player, ef);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
